mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter that shares one single-ported memory between the instruction-fetch port and the data-memory (MEM stage) port of the 5-stage core. It holds one outstanding memory transaction at a time using a req/ack handshake on every side. Data accesses have priority. A starvation counter forces a fetch grant after a bounded run of data grants. It sits between `cpu` and the unified memory model/bus.

## Interface
- `STARVE_LIMIT`, default 4: maximum consecutive data grants made while a fetch request is pending; range 1–15.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `i_if_req`  in  1  fetch request; held with its payload until `o_if_ack`.
- `i_if_addr`  in  32  fetch byte address.
- `o_if_ack`  out  1  one-cycle pulse; fetch completed.
- `o_if_rdata`  out  32  fetch read data; valid while `o_if_ack`=1.
- `i_dm_req`  in  1  data request; held with its payload until `o_dm_ack`.
- `i_dm_we`  in  1  1 = write, 0 = read.
- `i_dm_addr`  in  32  data address; word-aligned, as produced by `rw_mask`.
- `i_dm_wdata`  in  32  write data, pre-shifted into its byte lanes.
- `i_dm_wmask`  in  32  bit-granular lane mask.
- `o_dm_ack`  out  1  one-cycle pulse; data access completed.
- `o_dm_rdata`  out  32  data read data; valid while `o_dm_ack`=1.
- `o_mem_req`  out  1  memory request; asserted until `i_mem_ack`.
- `o_mem_we`, `o_mem_addr`, `o_mem_wdata`, `o_mem_wmask`  out  1/32/32/32  memory payload; stable while `o_mem_req`=1.
- `i_mem_ack`  in  1  memory completion; accepted only while `o_mem_req`=1.
- `i_mem_rdata`  in  32  memory read data; valid with `i_mem_ack`.

## Operation
- FSM states: IDLE, WAIT, DONE.
- **IDLE:** evaluate the requests.
  - If neither is pending, stay in IDLE.
  - Otherwise grant one requester, register its payload into `o_mem_*`, record the grantee (`owner`), and go to WAIT.
- **Grant rule:**
  - Only one requester pending: grant it.
  - Both pending: grant data unless `starve_cnt` == `STARVE_LIMIT`, in which case grant fetch.
- **Fetch-grant payload:** `o_mem_we`=0, `o_mem_wmask`=0, `o_mem_wdata`=0, `o_mem_addr`=`i_if_addr`.
- **`starve_cnt` (4 bits):**
  - On a fetch grant, clear to 0.
  - On a data grant with `i_if_req`=1, increment (saturating at `STARVE_LIMIT`).
  - On a data grant with `i_if_req`=0, clear to 0.
- **WAIT:** `o_mem_req`=1.
  - On `i_mem_ack`, latch `i_mem_rdata` into the grantee's rdata register and go to DONE.
  - `i_mem_ack` may arrive in the first WAIT cycle.
- **DONE:**
  - `o_mem_req`=0.
  - Pulse `o_if_ack` or `o_dm_ack` per `owner`; the rdata register is valid.
  - Requests are NOT sampled in DONE; this prevents re-granting a request that the requester drops the cycle after its ack.
  - Next state: IDLE.
- For a data write, the latched rdata is don't-care, but the ack still pulses.
- `i_mem_ack` outside WAIT is ignored.
- Requester req/payload changes while not yet granted are legal; the arbiter uses the value sampled at the grant edge.

## Timing
- **Reset (async assert, sync-safe release):**
  - State = IDLE, `starve_cnt`=0.
  - `o_mem_req`, `o_if_ack`, `o_dm_ack` = 0.
  - All 32-bit outputs = 0.
- **Reset mid-transaction:** `o_mem_req` drops immediately and the transaction is abandoned; no ack is issued after release.
- **Minimum latency:**
  - Request seen in IDLE at cycle 0.
  - `o_mem_req` high in cycle 1.
  - `i_mem_ack` in cycle 1.
  - Requester ack in cycle 2.
  - IDLE again in cycle 3.
- **General latency:** ack to the requester follows `i_mem_ack` by exactly 1 cycle.
- **Throughput:** at most one transaction per 3 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- **Simultaneous events:**
  - Both requests rising in the same cycle are resolved by the grant rule.
  - A new request arriving during WAIT/DONE waits for the next IDLE.

## Test plan
- **Single fetch:** `i_if_req`=1, addr 0x80000000; memory acks in the first WAIT cycle with 0x00000013 -> `o_mem_req` high in cycle 1 with we=0, wmask=0; `o_if_ack`=1 with rdata 0x00000013 in cycle 2; IDLE in cycle 3.
- **Data write with 3-cycle memory latency:** addr 0x100, wdata 0x0000AB00, wmask 0x0000FF00 -> payload stable for 3 cycles of `o_mem_req`; `o_dm_ack` exactly 1 cycle after `i_mem_ack`; no `o_if_ack`.
- **Contention, STARVE_LIMIT=4:** both requests held continuously, data re-asserted after each ack -> grants D,D,D,D,F,D,D,D,D,F; `starve_cnt` returns to 0 after each F.
- **No double grant:** requester drops req the cycle after its ack -> exactly one memory transaction per request; spurious `i_mem_ack` in IDLE/DONE is ignored.
- **Reset mid-WAIT:** assert `i_rst_n`=0 during WAIT -> `o_mem_req`=0 immediately; all outputs 0; after release a pending fetch is granted fresh, and no stale ack appears.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data port and shared memory port.
// The slave view belongs to the arbiter; the master view to its environment
// (core requesters plus memory model).
interface mem_arbiter_if;
  // instruction-fetch requester
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_ack;
  logic [31:0] o_if_rdata;

  // data (MEM stage) requester
  logic        i_dm_req;
  logic        i_dm_we;
  logic [31:0] i_dm_addr;
  logic [31:0] i_dm_wdata;
  logic [31:0] i_dm_wmask;
  logic        o_dm_ack;
  logic [31:0] o_dm_rdata;

  // shared single-ported memory
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] o_mem_wmask;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_ack, o_if_rdata,
    input  i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_wmask,
    output o_dm_ack, o_dm_rdata,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask,
    input  i_mem_ack, i_mem_rdata
  );

  modport master (
    output i_if_req, i_if_addr,
    input  o_if_ack, o_if_rdata,
    output i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_wmask,
    input  o_dm_ack, o_dm_rdata,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask,
    output i_mem_ack, i_mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one single-ported memory between instruction
// fetch and data access. One outstanding transaction at a time; data wins
// contention unless fetch has been starved for STARVE_LIMIT data grants.
// Every output is a flop, so there is no combinational input-to-output path.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4  // 1..15
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state;
  state_t      state_next;
  owner_t      owner;
  logic [3:0]  starve_cnt;

  logic        grant_if;
  logic        grant_dm;
  logic        mem_done;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_wmask;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  // Grant decision, only meaningful in IDLE: data first, fetch when starved.
  // NOTE: every always_comb output gets a default before any branch; a path
  // that leaves a signal unassigned would infer a latch.
  always_comb begin
    grant_dm = 1'b0;
    grant_if = 1'b0;
    if (state == IDLE) begin
      grant_dm = bus.i_dm_req && !(bus.i_if_req && (starve_cnt == LIMIT));
      grant_if = bus.i_if_req && !grant_dm;
    end
  end

  // The memory completion only counts while a transaction is outstanding.
  assign mem_done = (state == WAIT) && bus.i_mem_ack;

  // Next-state logic; DONE never looks at the requests so a requester that
  // drops its req the cycle after its ack is not granted twice.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (grant_if || grant_dm) state_next = WAIT;
      WAIT:    if (bus.i_mem_ack)        state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // Memory request tracks WAIT; reset drops it at once, abandoning any
  // transaction in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) mem_req <= 1'b0;
    else          mem_req <= (state_next == WAIT);
  end

  // Capture the grantee's payload and identity at the grant edge; held
  // unchanged until the next grant, so it is stable throughout WAIT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner     <= OWN_IF;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else if (grant_if) begin
      owner     <= OWN_IF;
      mem_we    <= 1'b0;
      mem_addr  <= bus.i_if_addr;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else if (grant_dm) begin
      owner     <= OWN_DM;
      mem_we    <= bus.i_dm_we;
      mem_addr  <= bus.i_dm_addr;
      mem_wdata <= bus.i_dm_wdata;
      mem_wmask <= bus.i_dm_wmask;
    end
  end

  // Starvation counter: counts data grants made while fetch was waiting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (grant_dm) begin
      if (!bus.i_if_req)          starve_cnt <= '0;
      else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Requester acks pulse for the single DONE cycle following i_mem_ack.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
    end else begin
      if_ack <= mem_done && (owner == OWN_IF);
      dm_ack <= mem_done && (owner == OWN_DM);
    end
  end

  // Read data is latched into the grantee's register on completion and held.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      if_rdata <= '0;
      dm_rdata <= '0;
    end else if (mem_done) begin
      if (owner == OWN_IF) if_rdata <= bus.i_mem_rdata;
      else                 dm_rdata <= bus.i_mem_rdata;
    end
  end

  assign bus.o_mem_req   = mem_req;
  assign bus.o_mem_we    = mem_we;
  assign bus.o_mem_addr  = mem_addr;
  assign bus.o_mem_wdata = mem_wdata;
  assign bus.o_mem_wmask = mem_wmask;
  assign bus.o_if_ack    = if_ack;
  assign bus.o_if_rdata  = if_rdata;
  assign bus.o_dm_ack    = dm_ack;
  assign bus.o_dm_rdata  = dm_rdata;

endmodule
